// File: rtl/pacman_map_writer_pkg.sv
// Shared tile codes, map geometry defaults and writer state type for the pacman map writer.
// Also holds the map bounds check, so the range test and the address generator agree.
package pacman_pkg;

    localparam logic [3:0] TILE_EMPTY  = 4'd0;
    localparam logic [3:0] TILE_WALL   = 4'd1;
    localparam logic [3:0] TILE_PILL   = 4'd2;
    localparam logic [3:0] TILE_PACMAN = 4'd3;

    localparam int MAP_W_DEF = 40;
    localparam int MAP_H_DEF = 30;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ERASE,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } wr_state_t;

    function automatic logic coord_ok(input logic [5:0] x, input logic [4:0] y,
                                      input int map_w, input int map_h);
        return (int'(x) < map_w) && (int'(y) < map_h);
    endfunction

endpackage

// File: rtl/pacman_map_writer_if.sv
// Coordinate inputs from the location controller and the RAM write port of the map writer.
// master drives coordinates and vblank; slave is the writer.
interface pacman_map_writer_if #(
    parameter int ADDR_W = 11
);
    logic [5:0]        curr_pacman_x;
    logic [4:0]        curr_pacman_y;
    logic [5:0]        next_pacman_x;
    logic [4:0]        next_pacman_y;
    logic              vblank;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              done;
    logic              busy;
    logic              oob_err;

    modport master (
        output curr_pacman_x, curr_pacman_y, next_pacman_x, next_pacman_y, vblank,
        input  wr_en, wr_addr, wr_data, done, busy, oob_err
    );

    modport slave (
        input  curr_pacman_x, curr_pacman_y, next_pacman_x, next_pacman_y, vblank,
        output wr_en, wr_addr, wr_data, done, busy, oob_err
    );
endinterface

// File: rtl/pacman_map_writer_addr_gen.sv
// Purpose: map cell address y*MAP_W + x plus in-range flag.
// Latency: combinational. Backpressure: none.
module map_addr_gen
    import pacman_pkg::*;
#(
    parameter int MAP_W  = MAP_W_DEF,
    parameter int MAP_H  = MAP_H_DEF,
    parameter int ADDR_W = 11
) (
    input  logic [5:0]        i_x,
    input  logic [4:0]        i_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_range
);
    logic [ADDR_W-1:0] w_x;
    logic [ADDR_W-1:0] w_y;

    assign w_x = ADDR_W'(i_x);
    assign w_y = ADDR_W'(i_y);

    generate
        if (MAP_W == 40) begin : g_shift_add
            // 40 = 32 + 8
            assign o_addr = (w_y << 5) + (w_y << 3) + w_x;
        end else begin : g_mul
            assign o_addr = w_y * ADDR_W'(MAP_W) + w_x;
        end
    endgenerate

    assign o_in_range = coord_ok(i_x, i_y, MAP_W, MAP_H);
endmodule

// File: rtl/pacman_map_writer.sv
// Purpose: commit pacman moves to map RAM (erase curr, write next, pulse done); PACMAN_MAP_WR_VBLANK_EN gates strobes to vblank.
// Latency: req in IDLE -> erase strobe +1, write strobe +2, done +3 (vblank build: strobes wait for vblank).
// Backpressure: none; inputs are latched on req and ignored until the sequence returns to IDLE.
module pacman_map_writer
    import pacman_pkg::*;
#(
    parameter int MAP_W  = MAP_W_DEF,
    parameter int MAP_H  = MAP_H_DEF,
    parameter int ADDR_W = 11
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    pacman_map_writer_if.slave   bus
);
    wr_state_t         r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [3:0]        r_wr_data;
    logic              r_done;
    logic              r_busy;
    logic              r_oob_err;
    logic [5:0]        r_cx, r_nx;
    logic [4:0]        r_cy, r_ny;

    logic              w_live, w_sel_next, w_req, w_next_ok, w_addr_ok, w_vb;
    logic [5:0]        w_ax;
    logic [4:0]        w_ay;
    logic [ADDR_W-1:0] w_addr;

`ifdef PACMAN_MAP_WR_VBLANK_EN
    assign w_vb       = bus.vblank;
    assign w_sel_next = (r_state == ST_WRITE);
`else
    logic w_vblank_unused;
    assign w_vblank_unused = bus.vblank;
    assign w_vb            = 1'b1;
    assign w_sel_next      = (r_state == ST_ERASE);
`endif

    // In INIT/IDLE the address comes straight from the inputs, since the latch happens on this same edge.
    assign w_live = (r_state == ST_INIT) || (r_state == ST_IDLE);
    assign w_ax   = w_live ? bus.curr_pacman_x : (w_sel_next ? r_nx : r_cx);
    assign w_ay   = w_live ? bus.curr_pacman_y : (w_sel_next ? r_ny : r_cy);

    assign w_req     = {bus.next_pacman_x, bus.next_pacman_y} != {bus.curr_pacman_x, bus.curr_pacman_y};
    assign w_next_ok = coord_ok(bus.next_pacman_x, bus.next_pacman_y, MAP_W, MAP_H);

    map_addr_gen #(.MAP_W(MAP_W), .MAP_H(MAP_H), .ADDR_W(ADDR_W)) u_addr_gen (
        .i_x        (w_ax),
        .i_y        (w_ay),
        .o_addr     (w_addr),
        .o_in_range (w_addr_ok)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= TILE_EMPTY;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_oob_err <= 1'b0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_nx      <= '0;
            r_ny      <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (w_vb) begin
                        if (w_addr_ok) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_addr;
                            r_wr_data <= TILE_PACMAN;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_oob_err <= 1'b1;
                            r_state   <= ST_ERR;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_req) begin
                        r_cx   <= bus.curr_pacman_x;
                        r_cy   <= bus.curr_pacman_y;
                        r_nx   <= bus.next_pacman_x;
                        r_ny   <= bus.next_pacman_y;
                        r_busy <= 1'b1;
                        if (!(w_addr_ok && w_next_ok)) begin
                            r_oob_err <= 1'b1;
                            r_state   <= ST_ERR;
                        end else begin
                            r_state <= ST_ERASE;
`ifndef PACMAN_MAP_WR_VBLANK_EN
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_addr;
                            r_wr_data <= TILE_EMPTY;
`endif
                        end
                    end
                end
`ifdef PACMAN_MAP_WR_VBLANK_EN
                ST_ERASE: if (w_vb) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_addr;
                    r_wr_data <= TILE_EMPTY;
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: if (w_vb) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_addr;
                    r_wr_data <= TILE_PACMAN;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
`else
                ST_ERASE: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_addr;
                    r_wr_data <= TILE_PACMAN;
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
`endif
                ST_ERR:  r_state <= ST_ERR;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
    assign bus.oob_err = r_oob_err;
endmodule

// File: tb/tb_pacman_map_writer.sv
// Directed bench for pacman_map_writer (default build): vector table of moves plus hand sequences for latch, reset abort and range errors.
module tb_pacman_map_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pacman_map_writer_if #(.ADDR_W(11)) bus ();

    pacman_map_writer #(.MAP_W(40), .MAP_H(30), .ADDR_W(11)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    typedef struct {
        logic [5:0]  cx;
        logic [4:0]  cy;
        logic [5:0]  nx;
        logic [4:0]  ny;
        logic [10:0] a_erase;
        logic [10:0] a_write;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_pos(input logic [5:0] cx, input logic [4:0] cy,
                           input logic [5:0] nx, input logic [4:0] ny);
        bus.curr_pacman_x = cx;
        bus.curr_pacman_y = cy;
        bus.next_pacman_x = nx;
        bus.next_pacman_y = ny;
    endtask

    initial begin
        vecs[0] = '{6'd20, 5'd20, 6'd19, 5'd20, 11'd820,  11'd819};
        vecs[1] = '{6'd0,  5'd0,  6'd1,  5'd0,  11'd0,    11'd1};
        vecs[2] = '{6'd39, 5'd29, 6'd38, 5'd29, 11'd1199, 11'd1198};
        vecs[3] = '{6'd5,  5'd3,  6'd5,  5'd4,  11'd125,  11'd165};
        vecs[4] = '{6'd39, 5'd0,  6'd0,  5'd1,  11'd39,   11'd40};
        vecs[5] = '{6'd10, 5'd29, 6'd10, 5'd28, 11'd1170, 11'd1130};

        bus.vblank = 1'b0;
        set_pos(6'd20, 5'd20, 6'd20, 5'd20);
        rst = 1'b1;
        step();
        step();
        chk("rst_wr_en",   bus.wr_en,   0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_done",    bus.done,    0);
        chk("rst_busy",    bus.busy,    1);
        chk("rst_oob",     bus.oob_err, 0);

        rst = 1'b0;
        step();
        chk("init_wr_en",   bus.wr_en,   1);
        chk("init_wr_addr", bus.wr_addr, 820);
        chk("init_wr_data", bus.wr_data, 3);
        chk("init_busy",    bus.busy,    0);
        step();
        chk("idle_wr_en", bus.wr_en, 0);
        chk("idle_busy",  bus.busy,  0);

        for (int i = 0; i < 6; i++) begin
            set_pos(vecs[i].cx, vecs[i].cy, vecs[i].nx, vecs[i].ny);
            step();
            chk($sformatf("v%0d_erase_en", i),   bus.wr_en,   1);
            chk($sformatf("v%0d_erase_addr", i), bus.wr_addr, int'(vecs[i].a_erase));
            chk($sformatf("v%0d_erase_data", i), bus.wr_data, 0);
            chk($sformatf("v%0d_erase_busy", i), bus.busy,    1);
            step();
            chk($sformatf("v%0d_write_en", i),   bus.wr_en,   1);
            chk($sformatf("v%0d_write_addr", i), bus.wr_addr, int'(vecs[i].a_write));
            chk($sformatf("v%0d_write_data", i), bus.wr_data, 3);
            chk($sformatf("v%0d_write_done", i), bus.done,    0);
            step();
            chk($sformatf("v%0d_done", i),       bus.done,    1);
            chk($sformatf("v%0d_done_wr_en", i), bus.wr_en,   0);
            set_pos(vecs[i].nx, vecs[i].ny, vecs[i].nx, vecs[i].ny);
            step();
            chk($sformatf("v%0d_post_done", i),  bus.done,    0);
            chk($sformatf("v%0d_post_busy", i),  bus.busy,    0);
            chk($sformatf("v%0d_post_wr_en", i), bus.wr_en,   0);
        end

        // Inputs changed mid-sequence must not affect the latched move.
        set_pos(6'd20, 5'd20, 6'd19, 5'd20);
        step();
        chk("latch_erase_addr", bus.wr_addr, 820);
        set_pos(6'd1, 5'd1, 6'd30, 5'd10);
        step();
        chk("latch_write_en",   bus.wr_en,   1);
        chk("latch_write_addr", bus.wr_addr, 819);
        set_pos(6'd19, 5'd20, 6'd19, 5'd20);
        step();
        chk("latch_done", bus.done, 1);
        step();
        step();
        chk("latch_no_retrigger", bus.wr_en, 0);

        // Reset during the write strobe aborts the move.
        set_pos(6'd19, 5'd20, 6'd19, 5'd21);
        step();
        chk("abort_erase_addr", bus.wr_addr, 819);
        step();
        chk("abort_write_addr", bus.wr_addr, 859);
        rst = 1'b1;
        set_pos(6'd19, 5'd20, 6'd19, 5'd20);
        step();
        chk("abort_wr_en", bus.wr_en, 0);
        chk("abort_done",  bus.done,  0);
        chk("abort_busy",  bus.busy,  1);
        rst = 1'b0;
        step();
        chk("abort_init_wr_en", bus.wr_en,   1);
        chk("abort_init_addr",  bus.wr_addr, 819);
        chk("abort_init_done",  bus.done,    0);
        step();
        chk("abort_idle_done", bus.done, 0);

        // Out-of-range x is sticky until reset.
        set_pos(6'd19, 5'd20, 6'd45, 5'd20);
        step();
        chk("oobx_wr_en", bus.wr_en,   0);
        chk("oobx_flag",  bus.oob_err, 1);
        chk("oobx_busy",  bus.busy,    1);
        set_pos(6'd19, 5'd20, 6'd19, 5'd20);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("oobx_hold%0d_flag", k), bus.oob_err, 1);
            chk($sformatf("oobx_hold%0d_wr", k),   bus.wr_en,   0);
            chk($sformatf("oobx_hold%0d_done", k), bus.done,    0);
        end
        rst = 1'b1;
        step();
        chk("oob_clear", bus.oob_err, 0);
        rst = 1'b0;
        step();
        step();

        // Out-of-range y, one past the last row.
        set_pos(6'd19, 5'd20, 6'd19, 5'd30);
        step();
        chk("ooby_flag",  bus.oob_err, 1);
        chk("ooby_wr_en", bus.wr_en,   0);
        step();
        chk("ooby_done", bus.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
